sensor_axil_regbank: RTL and testbench

//   Parametrised AXI4-Lite slave register bank for the sensor IP; replaces the fixed 4-register slave.

---
 rtl/sensor_axil_regbank.sv | 184 ++++++++++++++++++
 tb/tb_sensor_axil_regbank.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_axil_regbank.sv
// sensor_axil_regbank
//   AXI4-Lite slave exposing NUM_REGS 32-bit registers to the sensor IP.
//   Each slot is either RW (control, driven onto reg_out) or RO (status,
//   read straight from reg_in). Writes take AW and W independently into
//   holding registers and commit one cycle after both are present. Each
//   successful commit produces a one-cycle pulse on wr_pulse.
//
// Ports
//   ACLK, ARESETN        clock (rising edge) and asynchronous active-low reset
//   S_AXI_AW*            write-address channel (AWPROT ignored)
//   S_AXI_W*             write-data channel with byte strobes
//   S_AXI_B*             write response (OKAY / SLVERR)
//   S_AXI_AR*            read-address channel (ARPROT ignored)
//   S_AXI_R*             read data and response (OKAY / SLVERR)
//   reg_out              flattened RW register contents, RO slots driven 0
//   reg_in               flattened status inputs, only RO slots are used
//   wr_pulse             one-cycle pulse per register on a successful write
module sensor_axil_regbank #(
  parameter int                             DATA_WIDTH = 32,
  parameter int                             ADDR_WIDTH = 5,
  parameter int                             NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0]            RO_MASK    = 8'hF0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int         IDX_W       = ADDR_WIDTH - 2;
  localparam int         STRB_W      = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // init_done keeps every READY low until the first edge after reset release.
  logic                  init_done;
  logic                  aw_full;
  logic [IDX_W-1:0]      aw_idx;
  logic                  w_full;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;

  logic                  commit;
  logic                  wr_legal;
  logic [NUM_REGS-1:0]   wr_sel;
  logic [IDX_W-1:0]      ar_idx;
  logic                  rd_legal;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_src [NUM_REGS];

  logic unused_bits;
  assign unused_bits = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // A pending response blocks both write channels, so the holds can only
  // refill after the master has taken BRESP.
  assign S_AXI_AWREADY = init_done && !aw_full && !S_AXI_BVALID;
  assign S_AXI_WREADY  = init_done && !w_full  && !S_AXI_BVALID;
  assign S_AXI_ARREADY = init_done && !S_AXI_RVALID;

  assign commit = aw_full && w_full && !S_AXI_BVALID;
  assign ar_idx = S_AXI_ARADDR[ADDR_WIDTH-1:2];

  // Index decode by comparison keeps out-of-range indices (>= NUM_REGS)
  // naturally illegal without indexing past the end of the register array.
  always_comb begin
    wr_legal = 1'b0;
    rd_legal = 1'b0;
    rd_word  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (aw_idx == IDX_W'(i) && !RO_MASK[i]) begin
        wr_legal = 1'b1;
      end
      if (ar_idx == IDX_W'(i)) begin
        rd_legal = 1'b1;
        rd_word  = rd_src[i];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      assign wr_sel[gi] = commit && wr_legal && (aw_idx == IDX_W'(gi));

      if (RO_MASK[gi]) begin : g_ro
        assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = '0;
        assign rd_src[gi] = reg_in[gi*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_rw
        logic [DATA_WIDTH-1:0] reg_q;
        logic                  unused_status;
        assign unused_status = &{1'b0, reg_in[gi*DATA_WIDTH +: DATA_WIDTH]};

        always_ff @(posedge ACLK or negedge ARESETN) begin
          if (!ARESETN) begin
            reg_q <= RESET_VAL[gi*DATA_WIDTH +: DATA_WIDTH];
          end else if (wr_sel[gi]) begin
            for (int k = 0; k < STRB_W; k++) begin
              if (w_strb[k]) begin
                reg_q[k*8 +: 8] <= w_data[k*8 +: 8];
              end
            end
          end
        end

        assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = reg_q;
        assign rd_src[gi] = reg_q;
      end
    end
  endgenerate

  // Write path: capture AW/W independently, commit once both are held.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      init_done    <= 1'b0;
      aw_full      <= 1'b0;
      aw_idx       <= '0;
      w_full       <= 1'b0;
      w_data       <= '0;
      w_strb       <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
      wr_pulse     <= '0;
    end else begin
      init_done <= 1'b1;
      wr_pulse  <= wr_sel;
      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        aw_full <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
      end
      if (S_AXI_WVALID && S_AXI_WREADY) begin
        w_full <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (commit) begin
        aw_full      <= 1'b0;
        w_full       <= 1'b0;
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= wr_legal ? RESP_OKAY : RESP_SLVERR;
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
    end
  end

  // Read path: data is sampled at the AR accept edge, so a read landing on
  // the same edge as a commit returns the pre-write value.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= RESP_OKAY;
    end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
      S_AXI_RVALID <= 1'b1;
      S_AXI_RDATA  <= rd_legal ? rd_word : '0;
      S_AXI_RRESP  <= rd_legal ? RESP_OKAY : RESP_SLVERR;
    end else if (S_AXI_RVALID && S_AXI_RREADY) begin
      S_AXI_RVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sensor_axil_regbank.sv
// tb_sensor_axil_regbank
//   Randomised and directed bench for sensor_axil_regbank with six registers
//   (4 and 5 read-only). Stimulus tasks push expected B/R responses into
//   queues; a monitor pops them on each handshake and compares.
module tb_sensor_axil_regbank;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int N  = 6;
  localparam logic [N-1:0]    RO = 6'b110000;
  localparam logic [N*DW-1:0] RV = {32'h5555_0005, 32'h4444_0004, 32'hCAFE_0003,
                                    32'hBEEF_0002, 32'h1234_0001, 32'h0BAD_0000};

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [AW-1:0]   awaddr = '0;
  logic [2:0]      awprot = '0;
  logic            awvalid = 1'b0;
  logic            awready;
  logic [DW-1:0]   wdata = '0;
  logic [3:0]      wstrb = '0;
  logic            wvalid = 1'b0;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready = 1'b1;
  logic [AW-1:0]   araddr = '0;
  logic [2:0]      arprot = '0;
  logic            arvalid = 1'b0;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready = 1'b1;
  logic [N*DW-1:0] reg_out;
  logic [N*DW-1:0] reg_in = '0;
  logic [N-1:0]    wr_pulse;

  always #5 clk = ~clk;

  sensor_axil_regbank #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(N), .RO_MASK(RO), .RESET_VAL(RV)
  ) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse)
  );

  typedef struct packed { logic [1:0] resp; logic [N-1:0] pulse; } b_exp_t;
  typedef struct packed { logic [1:0] resp; logic [DW-1:0] data; } r_exp_t;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] model [N];
  b_exp_t        b_q [$];
  r_exp_t        r_q [$];
  b_exp_t        mon_b;
  r_exp_t        mon_r;
  logic          bvalid_prev = 1'b0;

  task automatic chk(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  function automatic void reset_model();
    for (int i = 0; i < N; i++) model[i] = RO[i] ? '0 : RV[i*DW +: DW];
  endfunction

  function automatic logic [N*DW-1:0] model_flat();
    logic [N*DW-1:0] f;
    for (int i = 0; i < N; i++) f[i*DW +: DW] = RO[i] ? '0 : model[i];
    return f;
  endfunction

  function automatic r_exp_t exp_read(input logic [AW-1:0] addr);
    r_exp_t e;
    int idx;
    idx = int'(addr[AW-1:2]);
    if (idx >= N) begin
      e.resp = 2'b10;
      e.data = '0;
    end else begin
      e.resp = 2'b00;
      e.data = RO[idx] ? reg_in[idx*DW +: DW] : model[idx];
    end
    return e;
  endfunction

  // Monitor: pulse check on the first BVALID cycle, response checks on handshakes.
  always @(negedge clk) begin
    if (bvalid && !bvalid_prev) begin
      if (b_q.size() == 0) chk("unexpected_bvalid", {{(N*DW-1){1'b0}}, bvalid}, '0);
      else chk("wr_pulse", {{(N*DW-N){1'b0}}, wr_pulse}, {{(N*DW-N){1'b0}}, b_q[0].pulse});
    end else begin
      chk("wr_pulse_idle", {{(N*DW-N){1'b0}}, wr_pulse}, '0);
    end
    if (bvalid && bready) begin
      if (b_q.size() == 0) begin
        chk("unexpected_b", {{(N*DW-1){1'b0}}, bvalid}, '0);
      end else begin
        mon_b = b_q.pop_front();
        chk("bresp", {{(N*DW-2){1'b0}}, bresp}, {{(N*DW-2){1'b0}}, mon_b.resp});
        $display("B  resp=%0d pulse=%b", bresp, mon_b.pulse);
      end
    end
    if (rvalid && rready) begin
      if (r_q.size() == 0) begin
        chk("unexpected_r", {{(N*DW-1){1'b0}}, rvalid}, '0);
      end else begin
        mon_r = r_q.pop_front();
        chk("rdata", {{(N*DW-DW){1'b0}}, rdata}, {{(N*DW-DW){1'b0}}, mon_r.data});
        chk("rresp", {{(N*DW-2){1'b0}}, rresp}, {{(N*DW-2){1'b0}}, mon_r.resp});
        $display("R  data=%08h resp=%0d", rdata, rresp);
      end
    end
    bvalid_prev = bvalid;
  end

  // Issue a write with independent AW/W delays; expectation is pushed first.
  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly);
    b_exp_t e;
    int     idx;
    int     cyc;
    bit     legal, aw_done, w_done, aw_hs, w_hs;
    idx   = int'(addr[AW-1:2]);
    legal = 1'b0;
    if (idx < N) legal = !RO[idx];
    if (legal)
      for (int k = 0; k < 4; k++) if (strb[k]) model[idx][k*8 +: 8] = data[k*8 +: 8];
    e.resp  = legal ? 2'b00 : 2'b10;
    e.pulse = legal ? (N'(1) << idx) : '0;
    b_q.push_back(e);
    aw_done = 1'b0;
    w_done  = 1'b0;
    cyc     = 0;
    while (!(aw_done && w_done)) begin
      if (cyc > 100) begin
        fail_now("write_accept");
        awvalid = 1'b0;
        wvalid  = 1'b0;
        break;
      end
      if (cyc == aw_dly && !aw_done) begin awaddr = addr; awvalid = 1'b1; end
      if (cyc == w_dly && !w_done) begin wdata = data; wstrb = strb; wvalid = 1'b1; end
      @(negedge clk);
      chk("early_bvalid", {{(N*DW-1){1'b0}}, bvalid}, '0);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin wvalid  = 1'b0; w_done  = 1'b1; end
      cyc++;
    end
    @(negedge clk);
    chk("bvalid_latency0", {{(N*DW-1){1'b0}}, bvalid}, '0);
    @(negedge clk);
    chk("bvalid_latency1", {{(N*DW-1){1'b0}}, bvalid}, 1);
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input int dly, input r_exp_t e);
    bit hs;
    int t;
    r_q.push_back(e);
    repeat (dly) begin @(posedge clk); #1; end
    araddr  = addr;
    arvalid = 1'b1;
    hs = 1'b0;
    t  = 0;
    while (!hs && t < 100) begin
      @(negedge clk);
      hs = arvalid && arready;
      @(posedge clk); #1;
      t++;
    end
    arvalid = 1'b0;
    if (!hs) fail_now("read_accept");
    @(negedge clk);
    chk("rvalid_latency", {{(N*DW-1){1'b0}}, rvalid}, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_b();
    int t = 0;
    while (b_q.size() != 0 && t < 50) begin @(posedge clk); #1; t++; end
    if (b_q.size() != 0) begin fail_now("b_response"); b_q.delete(); end
    @(posedge clk); #1;
    chk("reg_out", reg_out, model_flat());
  endtask

  task automatic wait_r();
    int t = 0;
    while (r_q.size() != 0 && t < 50) begin @(posedge clk); #1; t++; end
    if (r_q.size() != 0) begin fail_now("r_response"); r_q.delete(); end
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb);
    axi_write(addr, data, strb, 0, 0);
    wait_b();
  endtask

  task automatic do_read(input logic [AW-1:0] addr);
    axi_read(addr, 0, exp_read(addr));
    wait_r();
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_awready"}, {{(N*DW-1){1'b0}}, awready}, '0);
    chk({tag, "_wready"},  {{(N*DW-1){1'b0}}, wready}, '0);
    chk({tag, "_arready"}, {{(N*DW-1){1'b0}}, arready}, '0);
    chk({tag, "_bvalid"},  {{(N*DW-1){1'b0}}, bvalid}, '0);
    chk({tag, "_rvalid"},  {{(N*DW-1){1'b0}}, rvalid}, '0);
    chk({tag, "_resp"},    {{(N*DW-4){1'b0}}, bresp, rresp}, '0);
    chk({tag, "_rdata"},   {{(N*DW-DW){1'b0}}, rdata}, '0);
    chk({tag, "_pulse"},   {{(N*DW-N){1'b0}}, wr_pulse}, '0);
    chk({tag, "_reg_out"}, reg_out, model_flat());
  endtask

  task automatic check_ready_release(input string tag);
    @(negedge clk);
    chk({tag, "_ready_early"}, {{(N*DW-3){1'b0}}, awready, wready, arready}, '0);
    @(negedge clk);
    chk({tag, "_ready_up"}, {{(N*DW-3){1'b0}}, awready, wready, arready}, 3'b111);
    @(posedge clk); #1;
  endtask

  task automatic randomize_status();
    for (int i = 0; i < N; i++) reg_in[i*DW +: DW] = $urandom;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    r_exp_t e0;
    logic [AW-1:0] a;
    int t;
    bit hs;

    reset_model();
    randomize_status();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_ready_release("rel");

    // Basic write/readback of regs 0-3.
    for (int i = 0; i < 4; i++) do_write(AW'(i * 4), DW'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) do_read(AW'(i * 4));

    // W three cycles ahead of AW.
    axi_write(6'h08, 32'hA5A5_A5A5, 4'hF, 3, 0);
    wait_b();
    do_read(6'h08);

    // Byte strobes.
    do_write(6'h04, 32'h1122_3344, 4'hF);
    do_write(6'h04, 32'hFFFF_FFFF, 4'b0101);
    do_read(6'h04);

    // RO register and out-of-range indices.
    do_write(6'h14, 32'h0123_4567, 4'hF);
    for (int a_i = 6'h18; a_i <= 6'h3C; a_i += 4) do_write(AW'(a_i), $urandom, 4'hF);
    do_read(6'h14);
    do_read(6'h10);
    do_read(6'h20);

    // Zero strobe still pulses.
    do_write(6'h0C, 32'hFFFF_FFFF, 4'h0);
    do_read(6'h0C);

    // Read accepted on the commit edge returns the old value.
    e0 = exp_read(6'h00);
    fork
      axi_write(6'h00, 32'hDEAD_BEEF, 4'hF, 0, 0);
      axi_read(6'h00, 1, e0);
    join
    wait_b();
    wait_r();
    do_read(6'h00);

    // Back-pressure on B and R.
    bready = 1'b0;
    axi_write(6'h0C, 32'h5A5A_0F0F, 4'hF, 0, 0);
    awaddr = 6'h08;
    awvalid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("stall_bvalid", {{(N*DW-1){1'b0}}, bvalid}, 1);
      chk("stall_bresp", {{(N*DW-2){1'b0}}, bresp}, '0);
      chk("stall_awready", {{(N*DW-1){1'b0}}, awready}, '0);
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    bready = 1'b1;
    wait_b();
    rready = 1'b0;
    axi_read(6'h0C, 0, exp_read(6'h0C));
    repeat (10) begin
      @(negedge clk);
      chk("stall_rvalid", {{(N*DW-1){1'b0}}, rvalid}, 1);
      chk("stall_rdata", {{(N*DW-DW){1'b0}}, rdata}, {{(N*DW-DW){1'b0}}, model[3]});
      chk("stall_arready", {{(N*DW-1){1'b0}}, arready}, '0);
    end
    @(posedge clk); #1;
    rready = 1'b1;
    wait_r();

    // Randomised traffic.
    for (int n = 0; n < 40; n++) begin
      randomize_status();
      a = {4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 2) != 0) begin
        axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), $urandom_range(0, 3));
        wait_b();
      end else begin
        do_read(a);
      end
    end

    // Reset between AW accept and W: the orphan W must never commit.
    awaddr  = 6'h04;
    awvalid = 1'b1;
    hs = 1'b0;
    t  = 0;
    while (!hs && t < 50) begin
      @(negedge clk);
      hs = awvalid && awready;
      @(posedge clk); #1;
      t++;
    end
    awvalid = 1'b0;
    if (!hs) fail_now("midrst_aw_accept");
    rst_n = 1'b0;
    reset_model();
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_ready_release("midrel");
    wdata  = 32'h7777_7777;
    wstrb  = 4'hF;
    wvalid = 1'b1;
    hs = 1'b0;
    t  = 0;
    while (!hs && t < 50) begin
      @(negedge clk);
      hs = wvalid && wready;
      @(posedge clk); #1;
      t++;
    end
    wvalid = 1'b0;
    if (!hs) fail_now("midrst_w_accept");
    repeat (10) begin
      @(negedge clk);
      chk("midrst_no_bvalid", {{(N*DW-1){1'b0}}, bvalid}, '0);
      chk("midrst_reg_out", reg_out, model_flat());
    end
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) do_read(AW'(i * 4));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
